// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MULTU/DIVU sequencer that drives the shared ripple ALU one step per clock
// and folds its sum/carry back into HI/LO.
//
// state  | meaning
// IDLE   | waiting for start with a legal funct; ALU inputs held at zero
// RUN    | one shift-add (MULTU) or restoring-subtract (DIVU) step per clock
// DONE   | one-cycle done pulse, HI/LO valid
module alu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [5:0]       alu_signal,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_SUB  = 6'b100010;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_is_div;
  logic [WIDTH-1:0] r_operand;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_legal;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_rem;
  logic             w_m;
  logic             w_ok;

  assign w_legal  = (funct == FN_MULTU) || (funct == FN_DIVU);
  assign w_accept = (r_state == S_IDLE) && start && w_legal;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // Partial remainder shifted left by one; the bit shifted out of HI (m) means r >= divisor.
  assign w_rem = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_m   = r_hi[WIDTH-1];
  assign w_ok  = alu_cout | w_m;

  assign hi = r_hi;
  assign lo = r_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_RUN;
      S_RUN:   if (w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    alu_signal = ALU_ADD;
    alu_a      = '0;
    alu_b      = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_RUN: begin
        busy = 1'b1;
        if (r_is_div) begin
          alu_signal = ALU_SUB;
          alu_a      = w_rem;
          alu_b      = r_operand;
        end else begin
          alu_a = r_hi;
          alu_b = r_lo[0] ? r_operand : '0;
        end
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_div  <= 1'b0;
      r_operand <= '0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else if (w_accept) begin
      r_is_div  <= (funct == FN_DIVU);
      r_operand <= (funct == FN_DIVU) ? op_b : op_a;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= (funct == FN_DIVU) ? op_a : op_b;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (r_is_div) begin
        r_hi <= w_ok ? alu_out : w_rem;
        r_lo <= {r_lo[WIDTH-2:0], w_ok};
      end else begin
        // Carry becomes the new HI MSB; the product shifts right into LO as multiplier bits retire.
        {r_hi, r_lo} <= {alu_cout, alu_out, r_lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: behavioural ripple-ALU model plus
// arithmetic reference for product, quotient and remainder.
module tb_alu_muldiv_seq;

  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_SUB  = 6'b100010;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_signal;
  logic [31:0] alu_out;
  logic        alu_cout;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  alu_muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct(funct),
    .op_a(op_a), .op_b(op_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_signal(alu_signal),
    .alu_out(alu_out), .alu_cout(alu_cout),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // ALU: ADD gives a+b, SUB gives a+~b+1; carry is bit 32 of the sum.
  logic [32:0] alu_sum;
  assign alu_sum  = (alu_signal == ALU_SUB) ? ({1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1)
                                            : ({1'b0, alu_a} + {1'b0, alu_b});
  assign alu_out  = alu_sum[31:0];
  assign alu_cout = alu_sum[32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] a, b);
    if (f == FN_MULTU) return {32'd0, a} * {32'd0, b};
    if (b == 32'd0)    return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi_o, output logic [31:0] lo_o,
                        output int done_at, output int busy_cnt, output logic [5:0] sig1);
    @(negedge clk);
    funct = f; op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sig1 = alu_signal;
    done_at = 0; busy_cnt = 0; hi_o = '0; lo_o = '0;
    for (int s = 1; s <= 60; s++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_at = s; hi_o = hi; lo_o = lo;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if ({hi, lo} !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: hi=%h lo=%h busy=%b done=%b, required 0/0/0/0", hi, lo, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (alu_signal !== ALU_ADD || alu_a !== 32'd0 || alu_b !== 32'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_alu: sig=%b a=%h b=%h busy=%b, required %b/0/0/0",
               alu_signal, alu_a, alu_b, busy, ALU_ADD);
    end
  endtask

  task automatic test_multu_small;
    logic [31:0] h, l; int d, bc; logic [5:0] s1;
    run_op(FN_MULTU, 32'd7, 32'd6, h, l, d, bc, s1);
    n_checks++;
    if (d !== 33 || bc !== 33) begin
      n_fail++;
      $display("FAIL mul7x6_timing: done_at=%0d busy_cycles=%0d, required 33/33", d, bc);
    end
    n_checks++;
    if (h !== 32'd0 || l !== 32'd42) begin
      n_fail++;
      $display("FAIL mul7x6_result: hi=%h lo=%h, required 0/2a", h, l);
    end
    n_checks++;
    if (s1 !== ALU_ADD) begin
      n_fail++;
      $display("FAIL mul_alu_signal: got %b, required %b", s1, ALU_ADD);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd42) begin
      n_fail++;
      $display("FAIL mul_after_done: done=%b busy=%b hi=%h lo=%h, required 0/0/0/2a", done, busy, hi, lo);
    end
  endtask

  // Checks the partial product after every step, so each ALU carry-out is observed.
  task automatic test_multu_max;
    logic [31:0] a, b; logic [63:0] mask, exp; int bad_steps;
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; bad_steps = 0;
    @(negedge clk);
    funct = FN_MULTU; op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      mask = (64'd1 << k) - 64'd1;
      exp  = ((({32'd0, a} * ({32'd0, b} & mask))) << (32 - k)) + ({32'd0, b} >> k);
      n_checks++;
      if ({hi, lo} !== exp) begin
        n_fail++; bad_steps++;
        if (bad_steps <= 4)
          $display("FAIL mulmax_step%0d: hi_lo=%h, required %h", k, {hi, lo}, exp);
      end
    end
    n_checks++;
    if (done !== 1'b1 || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL mulmax_final: done=%b hi=%h lo=%h, required 1/fffffffe/00000001", done, hi, lo);
    end
  endtask

  task automatic test_divu;
    logic [31:0] h, l; int d, bc; logic [5:0] s1;
    logic [31:0] dv_a [3]; logic [31:0] dv_b [3]; logic [31:0] ex_q [3]; logic [31:0] ex_r [3];
    dv_a[0] = 32'd100;        dv_b[0] = 32'd7; ex_q[0] = 32'd14;          ex_r[0] = 32'd2;
    dv_a[1] = 32'h8000_0001;  dv_b[1] = 32'd2; ex_q[1] = 32'h4000_0000;   ex_r[1] = 32'd1;
    dv_a[2] = 32'h0000_1234;  dv_b[2] = 32'd0; ex_q[2] = 32'hFFFF_FFFF;   ex_r[2] = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      run_op(FN_DIVU, dv_a[i], dv_b[i], h, l, d, bc, s1);
      n_checks++;
      if (d !== 33 || l !== ex_q[i] || h !== ex_r[i]) begin
        n_fail++;
        $display("FAIL div_directed%0d: done_at=%0d q=%h r=%h, required 33/%h/%h", i, d, l, h, ex_q[i], ex_r[i]);
      end
      n_checks++;
      if (s1 !== ALU_SUB) begin
        n_fail++;
        $display("FAIL div_alu_signal%0d: got %b, required %b", i, s1, ALU_SUB);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b, h, l; int d, bc; logic [5:0] s1, f; logic [63:0] exp;
    for (int i = 0; i < 12; i++) begin
      f = ($urandom_range(0, 1) == 0) ? FN_MULTU : FN_DIVU;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(1, 15));
        1:       b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      exp = ref_result(f, a, b);
      run_op(f, a, b, h, l, d, bc, s1);
      n_checks++;
      if (d !== 33 || {h, l} !== exp) begin
        n_fail++;
        $display("FAIL random%0d f=%b a=%h b=%h: done_at=%0d hi_lo=%h, required 33/%h", i, f, a, b, d, {h, l}, exp);
      end
    end
  endtask

  task automatic test_start_ignored;
    int n_done; logic [31:0] h, l;
    n_done = 0; h = '0; l = '0;
    @(negedge clk);
    funct = FN_DIVU; op_a = 32'd1000; op_b = 32'd33; start = 1'b1;
    @(negedge clk);
    for (int s = 1; s <= 45; s++) begin
      if (s < 25) begin
        start = s[0];
        funct = s[1] ? FN_MULTU : FN_DIVU;
        op_a = $urandom; op_b = $urandom;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        n_done++; h = hi; l = lo;
      end
      @(negedge clk);
    end
    n_checks++;
    if (n_done !== 1 || l !== 32'd30 || h !== 32'd10) begin
      n_fail++;
      $display("FAIL start_during_run: dones=%0d q=%h r=%h, required 1/1e/a", n_done, l, h);
    end
  endtask

  task automatic test_illegal_funct;
    int n_busy; logic [31:0] h0, l0;
    n_busy = 0; h0 = hi; l0 = lo;
    @(negedge clk);
    funct = 6'b100000; op_a = 32'd5; op_b = 32'd9; start = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      if (busy || done) n_busy++;
    end
    start = 1'b0;
    n_checks++;
    if (n_busy !== 0 || hi !== h0 || lo !== l0 || alu_a !== 32'd0) begin
      n_fail++;
      $display("FAIL illegal_funct: busy_or_done_cycles=%0d hi=%h lo=%h alu_a=%h, required 0/%h/%h/0",
               n_busy, hi, lo, alu_a, h0, l0);
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] fs [3]; logic [31:0] as [3]; logic [31:0] bs [3];
    int last_done, gap, t;
    logic got;
    fs[0] = FN_MULTU; as[0] = $urandom; bs[0] = $urandom;
    fs[1] = FN_DIVU;  as[1] = $urandom; bs[1] = 32'($urandom_range(1, 1000));
    fs[2] = FN_MULTU; as[2] = $urandom; bs[2] = $urandom;
    @(negedge clk);
    funct = fs[0]; op_a = as[0]; op_b = bs[0]; start = 1'b1;
    t = 0; last_done = 0;
    for (int i = 0; i < 3; i++) begin
      got = 1'b0;
      for (int s = 0; s < 60; s++) begin
        @(negedge clk);
        t++;
        if (done) begin
          got = 1'b1;
          break;
        end
      end
      gap = t - last_done;
      n_checks++;
      if (!got || {hi, lo} !== ref_result(fs[i], as[i], bs[i])) begin
        n_fail++;
        $display("FAIL b2b_result%0d: got_done=%b hi_lo=%h, required 1/%h", i, got, {hi, lo},
                 ref_result(fs[i], as[i], bs[i]));
      end
      n_checks++;
      if (gap !== ((i == 0) ? 33 : 34)) begin
        n_fail++;
        $display("FAIL b2b_spacing%0d: cycles=%0d, required %0d", i, gap, (i == 0) ? 33 : 34);
      end
      last_done = t;
      if (i < 2) begin
        funct = fs[i+1]; op_a = as[i+1]; op_b = bs[i+1];
      end else begin
        start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int n_done;
    n_done = 0;
    @(negedge clk);
    funct = FN_MULTU; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5677; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_run: hi=%h lo=%h busy=%b done=%b, required 0/0/0/0", hi, lo, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 45; s++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    n_checks++;
    if (n_done !== 0) begin
      n_fail++;
      $display("FAIL reset_no_done: busy_or_done_cycles=%0d, required 0", n_done);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; funct = 6'd0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    test_reset;
    test_multu_small;
    test_multu_max;
    test_divu;
    test_random;
    test_start_ignored;
    test_illegal_funct;
    test_back_to_back;
    test_reset_mid_run;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
